// File: rtl/axi_cdc_src_guard.sv
// Outstanding-transaction limiter and isolation guard that sits in front of the AXI CDC source half.
// Payloads pass straight through; only the valid/ready handshakes are gated.

package axi_cdc_src_guard_pkg;

   typedef struct packed {
      logic [3:0]  id;
      logic [31:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
   } ax_chan_t;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  strb;
      logic        last;
   } w_chan_t;

   typedef struct packed {
      logic [3:0] id;
      logic [1:0] resp;
   } b_chan_t;

   typedef struct packed {
      logic [3:0]  id;
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
   } r_chan_t;

   typedef struct packed {
      ax_chan_t aw;
      logic     aw_valid;
      w_chan_t  w;
      logic     w_valid;
      logic     b_ready;
      ax_chan_t ar;
      logic     ar_valid;
      logic     r_ready;
   } axi_req_t;

   typedef struct packed {
      logic     aw_ready;
      logic     w_ready;
      b_chan_t  b;
      logic     b_valid;
      logic     ar_ready;
      r_chan_t  r;
      logic     r_valid;
   } axi_resp_t;

endpackage

module axi_cdc_src_guard #(
   parameter int unsigned MaxWTxns = 4,
   parameter int unsigned MaxRTxns = 4,
   parameter type axi_req_t  = axi_cdc_src_guard_pkg::axi_req_t,
   parameter type axi_resp_t = axi_cdc_src_guard_pkg::axi_resp_t
) (
   input  logic      src_clk_i,
   input  logic      src_rst_i,
   input  logic      isolate_i,
   output logic      isolated_o,
   input  axi_req_t  slv_req_i,
   output axi_resp_t slv_resp_o,
   output axi_req_t  mst_req_o,
   input  axi_resp_t mst_resp_i
);

   localparam int unsigned WCntW = $clog2(MaxWTxns + 1);
   localparam int unsigned RCntW = $clog2(MaxRTxns + 1);
   localparam logic [WCntW-1:0] WMax = WCntW'(MaxWTxns);
   localparam logic [RCntW-1:0] RMax = RCntW'(MaxRTxns);

   typedef enum logic [1:0] {
      StNormal,
      StDrain,
      StIsolated
   } state_e;

   state_e            r_state;
   state_e            w_stateNext;
   logic [WCntW-1:0]  r_wCnt;
   logic [RCntW-1:0]  r_rCnt;
   logic              r_awHold;
   logic              r_arHold;
   logic              r_isolated;

   logic              w_awEn;
   logic              w_arEn;
   logic              w_wEn;
   logic              w_awFire;
   logic              w_arFire;
   logic              w_bFire;
   logic              w_rLastFire;
   logic              w_drained;

   // A held AW/AR must stay visible downstream, so a hold overrides both state and limit.
   assign w_awEn = src_rst_i | r_awHold | ((r_state == StNormal) & (r_wCnt < WMax));
   assign w_arEn = src_rst_i | r_arHold | ((r_state == StNormal) & (r_rCnt < RMax));
   assign w_wEn  = src_rst_i | (r_state != StIsolated);

   assign w_awFire    = slv_req_i.aw_valid & w_awEn & mst_resp_i.aw_ready;
   assign w_arFire    = slv_req_i.ar_valid & w_arEn & mst_resp_i.ar_ready;
   assign w_bFire     = mst_resp_i.b_valid & slv_req_i.b_ready;
   assign w_rLastFire = mst_resp_i.r_valid & slv_req_i.r_ready & mst_resp_i.r.last;

   assign w_drained = (r_wCnt == '0) & (r_rCnt == '0) & ~r_awHold & ~r_arHold;

   always_comb begin
      mst_req_o  = slv_req_i;
      slv_resp_o = mst_resp_i;

      mst_req_o.aw_valid  = slv_req_i.aw_valid & w_awEn;
      slv_resp_o.aw_ready = mst_resp_i.aw_ready & w_awEn;
      mst_req_o.ar_valid  = slv_req_i.ar_valid & w_arEn;
      slv_resp_o.ar_ready = mst_resp_i.ar_ready & w_arEn;
      mst_req_o.w_valid   = slv_req_i.w_valid & w_wEn;
      slv_resp_o.w_ready  = mst_resp_i.w_ready & w_wEn;
   end

   always_comb begin
      w_stateNext = r_state;
      unique case (r_state)
         StNormal: begin
            if (isolate_i) w_stateNext = StDrain;
         end
         StDrain: begin
            if (!isolate_i)     w_stateNext = StNormal;
            else if (w_drained) w_stateNext = StIsolated;
         end
         StIsolated: begin
            if (!isolate_i) w_stateNext = StNormal;
         end
         default: w_stateNext = StNormal;
      endcase
   end

   always_ff @(posedge src_clk_i) begin
      if (src_rst_i) begin
         r_state    <= StNormal;
         r_isolated <= 1'b0;
      end else begin
         r_state    <= w_stateNext;
         r_isolated <= (w_stateNext == StIsolated);
      end
   end

   always_ff @(posedge src_clk_i) begin
      if (src_rst_i) begin
         r_awHold <= 1'b0;
         r_arHold <= 1'b0;
      end else begin
         r_awHold <= slv_req_i.aw_valid & w_awEn & ~mst_resp_i.aw_ready;
         r_arHold <= slv_req_i.ar_valid & w_arEn & ~mst_resp_i.ar_ready;
      end
   end

   // A decrement arriving at zero is an upstream protocol error; the count just stays at zero.
   always_ff @(posedge src_clk_i) begin
      if (src_rst_i) begin
         r_wCnt <= '0;
      end else if (w_awFire && !w_bFire) begin
         r_wCnt <= r_wCnt + WCntW'(1);
      end else if (w_bFire && !w_awFire && (r_wCnt != '0)) begin
         r_wCnt <= r_wCnt - WCntW'(1);
      end
   end

   always_ff @(posedge src_clk_i) begin
      if (src_rst_i) begin
         r_rCnt <= '0;
      end else if (w_arFire && !w_rLastFire) begin
         r_rCnt <= r_rCnt + RCntW'(1);
      end else if (w_rLastFire && !w_arFire && (r_rCnt != '0)) begin
         r_rCnt <= r_rCnt - RCntW'(1);
      end
   end

   assign isolated_o = r_isolated;

   wCntUnderflow : assert property (@(posedge src_clk_i) disable iff (src_rst_i)
      !(w_bFire && !w_awFire && (r_wCnt == '0)));
   rCntUnderflow : assert property (@(posedge src_clk_i) disable iff (src_rst_i)
      !(w_rLastFire && !w_arFire && (r_rCnt == '0)));

endmodule
